// File: rtl/icache_ctrl.sv
// Direct-mapped one-word-per-line instruction cache controller.
// Serves hits in one cycle and sequences a single outstanding miss.
module icache_ctrl #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              discard,
  input  logic              flush_all,
  input  logic              fe_req,
  input  logic [ADDR_W-1:0] fe_addr,
  output logic              fe_ready,
  output logic [DATA_W-1:0] fe_data,
  output logic              mc_req,
  output logic [ADDR_W-1:0] mc_addr,
  output logic              mc_discard,
  input  logic              mc_ready,
  input  logic [DATA_W-1:0] mc_data
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic                  unused_addr_lsb;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  logic [INDEX_BITS-1:0] m_idx_q;
  logic [TAG_W-1:0]      m_tag_q;

  logic lookup;
  logic do_hit;
  logic do_miss;
  logic fill;
  logic ret;

  assign idx = fe_addr[INDEX_BITS+1:2];
  assign tag = fe_addr[ADDR_W-1:INDEX_BITS+2];
  assign unused_addr_lsb = ^fe_addr[1:0];

  // A flush in the lookup cycle forces a miss.
  assign hit = valid_q[idx]
             && (tag_q[idx] == tag)
             && !flush_all;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (do_miss) state_d = MISS;
      end
      MISS: begin
        if (mc_ready || discard) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and event decode.
  always_comb begin
    lookup     = 1'b0;
    do_hit     = 1'b0;
    do_miss    = 1'b0;
    fill       = 1'b0;
    ret        = 1'b0;
    mc_req     = 1'b0;
    mc_discard = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        lookup  = fe_req && !discard;
        do_hit  = lookup && hit;
        do_miss = lookup && !hit;
      end
      (state_q == MISS): begin
        mc_req     = 1'b1;
        mc_discard = discard;
        fill       = mc_ready;
        ret        = mc_ready && !discard;
      end
      default: ;
    endcase
  end

  // Valid bits: flush wins over a same-cycle fill.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[m_idx_q] <= 1'b1;
    end
  end

  // Tag and data arrays, written on every fill.
  always_ff @(posedge clock) begin
    if (reset && fill) begin
      tag_q[m_idx_q]  <= m_tag_q;
      data_q[m_idx_q] <= mc_data;
    end
  end

  // Capture the line coordinates of a new miss.
  always_ff @(posedge clock) begin
    if (do_miss) begin
      m_idx_q <= idx;
      m_tag_q <= tag;
    end
  end

  // Registered frontend response and miss address.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fe_ready <= 1'b0;
      fe_data  <= '0;
      mc_addr  <= '0;
    end else begin
      fe_ready <= do_hit || ret;
      unique case (1'b1)
        do_hit:  fe_data <= data_q[idx];
        ret:     fe_data <= mc_data;
        default: ;
      endcase
      if (do_miss) begin
        mc_addr <= {fe_addr[ADDR_W-1:2], 2'b00};
      end
    end
  end

endmodule
